fifo_out_drain: RTL and testbench

Downstream stage of the transaction layer. Round-robin drains the four output FIFOs into a single tagged word stream with a valid/ready handshake. Keeps a saturating per-FIFO count of delivered words, readable through a req/idx port. Pops a FIFO only when it is non-empty and the previous word has been accepted downstream.

---
 rtl/fifo_out_drain_if.sv | 24 ++
 rtl/fifo_out_drain.sv | 159 +++++++++++++++
 tb/tb_fifo_out_drain.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_out_drain_if.sv
// Tagged output word stream of the drain stage.
// The master drives word/tag/valid and the slave answers with ready.
interface fifo_out_drain_if #(
  parameter int FIFO_WORD_SIZE = 10
);
  logic [FIFO_WORD_SIZE-1:0] out_data;
  logic [1:0]                out_src;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output out_data,
    output out_src,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_src,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fifo_out_drain.sv
// Round-robin drain of the four output FIFOs into one tagged valid/ready
// word stream, with saturating per-FIFO delivered-word counters that can
// be read back through a registered req/idx port.
module fifo_out_drain #(
  parameter int NUM_OUT        = 4,
  parameter int FIFO_WORD_SIZE = 10,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_OUT-1:0]        fifo_empty,
  input  logic [FIFO_WORD_SIZE-1:0] data_out0,
  input  logic [FIFO_WORD_SIZE-1:0] data_out1,
  input  logic [FIFO_WORD_SIZE-1:0] data_out2,
  input  logic [FIFO_WORD_SIZE-1:0] data_out3,
  output logic [NUM_OUT-1:0]        pop_FIFO_out,
  fifo_out_drain_if.master          out_if,
  input  logic                      clear_counts,
  input  logic                      req,
  input  logic [1:0]                idx,
  output logic [CNT_WIDTH-1:0]      data,
  output logic                      valid
);

  typedef enum logic [1:0] {SCAN, POP, CAPT, HOLD} state_t;

  state_t                    state_reg;
  logic [1:0]                rr_ptr_reg;
  logic [1:0]                sel_reg;
  logic [NUM_OUT-1:0]        pop_reg;
  logic [FIFO_WORD_SIZE-1:0] out_data_reg;
  logic [1:0]                out_src_reg;
  logic                      out_valid_reg;
  logic [CNT_WIDTH-1:0]      data_reg;
  logic                      valid_reg;

  logic [CNT_WIDTH-1:0]      count_reg  [NUM_OUT];
  logic [CNT_WIDTH-1:0]      count_next [NUM_OUT];

  logic                      scan_found;
  logic [1:0]                scan_idx;
  logic [1:0]                cand;
  logic [FIFO_WORD_SIZE-1:0] data_sel;
  logic                      deliver;

  // A word is delivered on the HOLD cycle in which downstream is ready.
  assign deliver = (state_reg == HOLD) && out_if.out_ready;

  // First non-empty FIFO at or after rr_ptr; walking down lets the
  // closest candidate overwrite the farther ones.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = rr_ptr_reg;
    cand       = '0;
    for (int k = NUM_OUT - 1; k >= 0; k--) begin
      cand = rr_ptr_reg + 2'(k);
      if (!fifo_empty[cand]) begin
        scan_found = 1'b1;
        scan_idx   = cand;
      end
    end
  end

  // Read-data mux for the selected FIFO, used in the capture cycle.
  always_comb begin
    case (sel_reg)
      2'd0:    data_sel = data_out0;
      2'd1:    data_sel = data_out1;
      2'd2:    data_sel = data_out2;
      default: data_sel = data_out3;
    endcase
  end

  // Drain FSM: select and pop, wait one cycle for FIFO read data,
  // capture it, then hold it until the downstream handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= SCAN;
      rr_ptr_reg    <= '0;
      sel_reg       <= '0;
      pop_reg       <= '0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        SCAN: begin
          if (enable && scan_found) begin
            sel_reg   <= scan_idx;
            pop_reg   <= {{(NUM_OUT-1){1'b0}}, 1'b1} << scan_idx;
            state_reg <= POP;
          end else begin
            pop_reg <= '0;
          end
        end
        POP: begin
          pop_reg   <= '0;
          state_reg <= CAPT;
        end
        CAPT: begin
          out_data_reg  <= data_sel;
          out_src_reg   <= sel_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end
        HOLD: begin
          if (out_if.out_ready) begin
            out_valid_reg <= 1'b0;
            rr_ptr_reg    <= sel_reg + 2'd1;
            state_reg     <= SCAN;
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  // Per-FIFO counter update: clear wins over increment, and a full
  // counter sticks at all-ones instead of wrapping.
  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : gen_cnt
      assign count_next[gi] =
          clear_counts ? '0 :
          (deliver && (sel_reg == 2'(gi)) && (count_reg[gi] != '1)) ?
              count_reg[gi] + 1'b1 : count_reg[gi];
    end
  endgenerate

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        count_reg[i] <= '0;
      end
    end else begin
      count_reg <= count_next;
    end
  end

  // Registered counter readout; sees the value before any same-cycle update.
  always_ff @(posedge clk) begin
    if (reset || !req) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      data_reg  <= count_reg[idx];
      valid_reg <= 1'b1;
    end
  end

  assign pop_FIFO_out     = pop_reg;
  assign out_if.out_data  = out_data_reg;
  assign out_if.out_src   = out_src_reg;
  assign out_if.out_valid = out_valid_reg;
  assign data             = data_reg;
  assign valid            = valid_reg;

endmodule

// File: tb/tb_fifo_out_drain.sv
// Directed bench for fifo_out_drain with a small FIFO read-port model.
module tb_fifo_out_drain;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [3:0]   fifo_empty;
  logic [3:0]   pop;
  logic         clear_counts;
  logic         req;
  logic [1:0]   idx;
  logic [4:0]   data;
  logic         valid;

  logic [W-1:0] fifo_word [4] = '{10'h040, 10'h0C0, 10'h278, 10'h3A0};
  logic [W-1:0] exp_word  [4] = '{10'h040, 10'h0C0, 10'h278, 10'h3A0};
  logic [W-1:0] dout      [4] = '{default: 10'h3FF};

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int pop_at;
  int prev_pop;
  logic [W-1:0] held;

  fifo_out_drain_if #(.FIFO_WORD_SIZE(W)) out_if ();

  fifo_out_drain dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .data_out0    (dout[0]),
    .data_out1    (dout[1]),
    .data_out2    (dout[2]),
    .data_out3    (dout[3]),
    .pop_FIFO_out (pop),
    .out_if       (out_if),
    .clear_counts (clear_counts),
    .req          (req),
    .idx          (idx),
    .data         (data),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO read ports: data is valid only the cycle after a pop, junk otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      dout[i] <= pop[i] ? fifo_word[i] : 10'h3FF;
      if (pop[i]) fifo_word[i] <= fifo_word[i] + 10'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until a pop appears (bounded), then check which FIFO was popped.
  task automatic wait_pop(input string tag, input logic [3:0] exp_pop, output int at);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (pop == 4'b0 && n < 20);
    at = cyc;
    chk({tag, " pop"}, pop, exp_pop);
  endtask

  // Step until out_valid rises (bounded), then check the tagged word.
  task automatic wait_valid(input string tag, input logic [1:0] exp_src, input logic [W-1:0] exp_dat);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!out_if.out_valid && n < 10);
    chk({tag, " out_valid"}, out_if.out_valid, 1);
    chk({tag, " out_src"}, out_if.out_src, exp_src);
    chk({tag, " out_data"}, out_if.out_data, exp_dat);
  endtask

  initial begin
    // Reset held two cycles with every FIFO empty.
    reset = 1'b1; enable = 1'b0; fifo_empty = 4'hF; clear_counts = 1'b0;
    req = 1'b0; idx = 2'd0; out_if.out_ready = 1'b0;
    step(); step();
    chk("rst pop", pop, 0);
    chk("rst out_valid", out_if.out_valid, 0);
    chk("rst out_data", out_if.out_data, 0);
    chk("rst out_src", out_if.out_src, 0);
    chk("rst data", data, 0);
    chk("rst valid", valid, 0);
    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle pop", pop, 0);
      chk("idle out_valid", out_if.out_valid, 0);
    end

    // Single word from FIFO2.
    fifo_empty = 4'b1011; out_if.out_ready = 1'b1;
    step();
    chk("single pop", pop, 4'b0100);
    fifo_empty = 4'hF;
    step();
    chk("single pop one cycle", pop, 0);
    chk("single no early valid", out_if.out_valid, 0);
    step();
    chk("single out_valid", out_if.out_valid, 1);
    chk("single out_data", out_if.out_data, 10'h278);
    chk("single out_src", out_if.out_src, 2);
    exp_word[2]++;
    req = 1'b1; idx = 2'd2;
    step();
    chk("single valid one cycle", out_if.out_valid, 0);
    chk("read pre-increment", data, 0);
    chk("read valid", valid, 1);
    step();
    chk("read count2", data, 1);
    req = 1'b0;
    step();
    chk("read idle data", data, 0);
    chk("read idle valid", valid, 0);

    // Reset to restart round robin at FIFO0; enable=0 blocks selection.
    reset = 1'b1; step(); reset = 1'b0;
    fifo_empty = 4'b0000; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("disabled pop", pop, 0);
    end
    enable = 1'b1;

    // Round robin 0,1,2,3,0,1 with pops 4 cycles apart.
    prev_pop = 0;
    for (int w = 0; w < 6; w++) begin
      wait_pop("rr", 4'b0001 << (w % 4), pop_at);
      if (w > 0) chk("rr pop spacing", pop_at - prev_pop, 4);
      prev_pop = pop_at;
      wait_valid("rr", 2'(w % 4), exp_word[w % 4]);
      exp_word[w % 4]++;
    end
    step();
    out_if.out_ready = 1'b0;

    // Backpressure on a FIFO2 word; enable drops meanwhile without effect.
    wait_pop("bp", 4'b0100, pop_at);
    wait_valid("bp", 2'd2, exp_word[2]);
    held = exp_word[2];
    exp_word[2]++;
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp valid held", out_if.out_valid, 1);
      chk("bp data held", out_if.out_data, held);
      chk("bp no pop", pop, 0);
      step();
    end
    chk("bp valid before ready", out_if.out_valid, 1);
    out_if.out_ready = 1'b1; enable = 1'b1;
    step();
    chk("bp handshake", out_if.out_valid, 0);
    chk("bp no pop yet", pop, 0);
    step();
    chk("bp next pop", pop, 4'b1000);
    wait_valid("bp next", 2'd3, exp_word[3]);
    exp_word[3]++;
    step();
    fifo_empty = 4'hF;

    // Clear, then 35 words from FIFO1 to saturate its counter.
    clear_counts = 1'b1; step(); clear_counts = 1'b0;
    req = 1'b1; idx = 2'd3;
    step();
    chk("clear count3", data, 0);
    req = 1'b0;
    fifo_empty = 4'b1101;
    for (int w = 0; w < 35; w++) begin
      wait_pop("sat", 4'b0010, pop_at);
      wait_valid("sat", 2'd1, exp_word[1]);
      exp_word[1]++;
    end
    step();
    fifo_empty = 4'hF;
    req = 1'b1; idx = 2'd1;
    step();
    chk("sat count1", data, 31);
    chk("sat valid", valid, 1);
    idx = 2'd0;
    step();
    chk("sat count0", data, 0);
    req = 1'b0;
    clear_counts = 1'b1; step(); clear_counts = 1'b0;
    req = 1'b1; idx = 2'd1;
    step();
    chk("cleared count1", data, 0);
    req = 1'b0;

    // Reset while a FIFO2 word is held: word lost, next pick is FIFO0.
    fifo_empty = 4'b0000; out_if.out_ready = 1'b0;
    wait_pop("mid", 4'b0100, pop_at);
    wait_valid("mid", 2'd2, exp_word[2]);
    exp_word[2]++;
    reset = 1'b1;
    step();
    chk("mid rst out_valid", out_if.out_valid, 0);
    chk("mid rst pop", pop, 0);
    reset = 1'b0; out_if.out_ready = 1'b1;
    wait_pop("post rst", 4'b0001, pop_at);
    wait_valid("post rst", 2'd0, exp_word[0]);
    exp_word[0]++;
    step();
    fifo_empty = 4'hF;
    req = 1'b1; idx = 2'd2;
    step();
    chk("lost word not counted", data, 0);
    idx = 2'd0;
    step();
    chk("post rst count0", data, 1);
    req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
